activation_sequencer: RTL and testbench

- Control stage directly upstream of the activation unit's index up-counter.
- Accepts a start command with a base index and an element count, then drives the counter's clock_enable, load_enable, load_value and synchronous reset so the counter sweeps exactly `length` indices.
- Presents each index to the downstream datapath with a valid/ready handshake and signals completion with a done pulse.
- Counter iterator is fed back in and forwarded as the element index.

---
 rtl/activation_sequencer.sv | 120 ++++++++++++
 tb/tb_activation_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/activation_sequencer.sv
// Sequencer that drives the activation unit's index up-counter and forwards each index downstream.
// Optional stall-cycle counter enabled by defining ACT_SEQ_STALL_COUNT_EN.
module activation_sequencer #(
   parameter int COUNTER_WIDTH = 6,
   parameter int LENGTH_WIDTH  = COUNTER_WIDTH + 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic [COUNTER_WIDTH-1:0] base_value,
   input  logic [LENGTH_WIDTH-1:0]  length,
   input  logic [COUNTER_WIDTH-1:0] iterator,
   input  logic                     out_ready,
   output logic                     counter_clock_enable,
   output logic                     counter_load_enable,
   output logic [COUNTER_WIDTH-1:0] counter_load_value,
   output logic                     counter_reset,
   output logic                     elem_valid,
   output logic [COUNTER_WIDTH-1:0] elem_index,
   output logic                     busy,
   output logic                     done,
   output logic [15:0]              stall_cycles
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]               state_reg, state_next;
   logic [COUNTER_WIDTH-1:0] base_reg, base_next;
   logic [LENGTH_WIDTH-1:0]  remaining_reg, remaining_next;

   logic in_idle, in_load, in_run, in_done;
   logic abort_active, transfer, start_accept;

   assign in_idle      = (state_reg == IDLE);
   assign in_load      = (state_reg == LOAD);
   assign in_run       = (state_reg == RUN);
   assign in_done      = (state_reg == DONE);
   assign abort_active = abort && !in_idle;
   assign start_accept = in_idle && start;
   // Abort outranks a handshake, so no element completes on an abort cycle.
   assign transfer     = in_run && out_ready && !abort;

   always_comb begin
      state_next     = state_reg;
      base_next      = base_reg;
      remaining_next = remaining_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               base_next      = base_value;
               remaining_next = length;
               state_next     = (length == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            state_next = abort ? IDLE : RUN;
         end
         RUN: begin
            if (abort) begin
               state_next = IDLE;
            end else if (out_ready) begin
               remaining_next = remaining_reg - LENGTH_WIDTH'(1);
               if (remaining_reg == LENGTH_WIDTH'(1)) begin
                  state_next = DONE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         base_reg      <= '0;
         remaining_reg <= '0;
      end else begin
         state_reg     <= state_next;
         base_reg      <= base_next;
         remaining_reg <= remaining_next;
      end
   end

   assign counter_clock_enable = (in_load && !abort) || transfer;
   assign counter_load_enable  = in_load && !abort;
   assign counter_load_value   = base_reg;
   assign counter_reset        = abort_active;
   assign elem_valid           = in_run && !abort;
   // Gated by reset so the index bus is quiet while the block is held in reset.
   assign elem_index           = reset ? iterator : '0;
   assign busy                 = !in_idle;
   assign done                 = in_done && !abort;

`ifdef ACT_SEQ_STALL_COUNT_EN
   logic [15:0] stall_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_reg <= '0;
      end else if (start_accept) begin
         stall_reg <= '0;
      end else if (in_run && !out_ready && (stall_reg != 16'hFFFF)) begin
         stall_reg <= stall_reg + 16'd1;
      end
   end

   assign stall_cycles = stall_reg;
`else
   logic unused_start_accept;
   assign unused_start_accept = start_accept;
   assign stall_cycles        = '0;
`endif

endmodule

// File: tb/tb_activation_sequencer.sv
// Directed testbench for activation_sequencer with a behavioural model of the external up-counter.
module tb_activation_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [5:0]  base_value = '0;
   logic [6:0]  length = '0;
   logic [5:0]  iterator = '0;
   logic        out_ready = 1'b0;
   logic        counter_clock_enable;
   logic        counter_load_enable;
   logic [5:0]  counter_load_value;
   logic        counter_reset;
   logic        elem_valid;
   logic [5:0]  elem_index;
   logic        busy;
   logic        done;
   logic [15:0] stall_cycles;

   int checks = 0;
   int errors = 0;

   activation_sequencer #(.COUNTER_WIDTH(6), .LENGTH_WIDTH(7)) dut (
      .clock                (clock),
      .reset                (reset),
      .start                (start),
      .abort                (abort),
      .base_value           (base_value),
      .length               (length),
      .iterator             (iterator),
      .out_ready            (out_ready),
      .counter_clock_enable (counter_clock_enable),
      .counter_load_enable  (counter_load_enable),
      .counter_load_value   (counter_load_value),
      .counter_reset        (counter_reset),
      .elem_valid           (elem_valid),
      .elem_index           (elem_index),
      .busy                 (busy),
      .done                 (done),
      .stall_cycles         (stall_cycles)
   );

   always #5 clock = ~clock;

   // External index counter: synchronous reset, load, increment.
   always @(posedge clock) begin
      if (counter_reset)
         iterator <= '0;
      else if (counter_clock_enable)
         iterator <= counter_load_enable ? counter_load_value : iterator + 6'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change here, checks follow after #2.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [5:0] exp_idx;
      logic [15:0] exp_stall;

      // Reset state
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_valid", elem_valid, 0);
      chk("rst_ce", counter_clock_enable, 0);
      chk("rst_creset", counter_reset, 0);
      chk("rst_index", elem_index, 0);
      chk("rst_stall", stall_cycles, 0);
      tick();
      reset = 1'b1;
      tick();

      // Sweep base=5 length=4, no stall: cycle 1 is the start cycle
      base_value = 6'd5; length = 7'd4; out_ready = 1'b1; start = 1'b1;
      #2;
      chk("s1_c1_busy", busy, 0);
      chk("s1_c1_le", counter_load_enable, 0);
      tick(); start = 1'b0; #2;
      chk("s1_c2_le", counter_load_enable, 1);
      chk("s1_c2_ce", counter_clock_enable, 1);
      chk("s1_c2_lv", counter_load_value, 5);
      chk("s1_c2_valid", elem_valid, 0);
      chk("s1_c2_busy", busy, 1);
      for (int i = 0; i < 4; i++) begin
         tick(); #2;
         exp_idx = 6'd5 + 6'(i);
         chk($sformatf("s1_valid%0d", i), elem_valid, 1);
         chk($sformatf("s1_index%0d", i), elem_index, exp_idx);
         chk($sformatf("s1_le%0d", i), counter_load_enable, 0);
         chk($sformatf("s1_ce%0d", i), counter_clock_enable, 1);
         chk($sformatf("s1_done%0d", i), done, 0);
      end
      tick(); #2;
      chk("s1_c7_done", done, 1);
      chk("s1_c7_busy", busy, 1);
      chk("s1_c7_valid", elem_valid, 0);
      chk("s1_c7_ce", counter_clock_enable, 0);
      tick(); #2;
      chk("s1_idle_busy", busy, 0);
      chk("s1_idle_done", done, 0);

      // Wrap-around: base=62 length=4 -> 62,63,0,1
      base_value = 6'd62; length = 7'd4; start = 1'b1;
      tick(); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(); #2;
         exp_idx = 6'd62 + 6'(i);
         chk($sformatf("wrap_index%0d", i), elem_index, exp_idx);
         chk($sformatf("wrap_valid%0d", i), elem_valid, 1);
      end
      tick(); #2;
      chk("wrap_done", done, 1);
      tick(); #2;
      chk("wrap_done_once", done, 0);
      chk("wrap_idle", busy, 0);

      // length=0: straight to DONE, no counter activity
      base_value = 6'd9; length = 7'd0; start = 1'b1;
      #2;
      chk("len0_start_ce", counter_clock_enable, 0);
      tick(); start = 1'b0; #2;
      chk("len0_done", done, 1);
      chk("len0_valid", elem_valid, 0);
      chk("len0_ce", counter_clock_enable, 0);
      chk("len0_le", counter_load_enable, 0);
      chk("len0_creset", counter_reset, 0);
      tick(); #2;
      chk("len0_idle", busy, 0);

      // Stall: base=0 length=3, out_ready low for the first two valid cycles
      base_value = 6'd0; length = 7'd3; start = 1'b1;
      tick(); start = 1'b0;
      tick(); out_ready = 1'b0; #2;
      chk("stall_idx0a", elem_index, 0);
      chk("stall_ce0a", counter_clock_enable, 0);
      tick(); #2;
      chk("stall_idx0b", elem_index, 0);
      chk("stall_valid0b", elem_valid, 1);
      tick(); out_ready = 1'b1; #2;
      chk("stall_idx0c", elem_index, 0);
      chk("stall_ce0c", counter_clock_enable, 1);
      tick(); #2;
      chk("stall_idx1", elem_index, 1);
      tick(); #2;
      chk("stall_idx2", elem_index, 2);
      tick(); #2;
      chk("stall_done", done, 1);
`ifdef ACT_SEQ_STALL_COUNT_EN
      exp_stall = 16'd2;
`else
      exp_stall = 16'd0;
`endif
      chk("stall_count", stall_cycles, exp_stall);
      tick(); #2;
      chk("stall_count_hold", stall_cycles, exp_stall);

      // Abort during the 2nd element of a length=8 sweep
      base_value = 6'd20; length = 7'd8; start = 1'b1;
      tick(); start = 1'b0;
      tick(); #2;
      chk("abort_idx0", elem_index, 20);
      tick(); abort = 1'b1; #2;
      chk("abort_idx1", elem_index, 21);
      chk("abort_creset", counter_reset, 1);
      chk("abort_ce", counter_clock_enable, 0);
      chk("abort_le", counter_load_enable, 0);
      chk("abort_done", done, 0);
      tick(); abort = 1'b0; #2;
      chk("abort_idle", busy, 0);
      chk("abort_creset_off", counter_reset, 0);
      chk("abort_no_done", done, 0);
      chk("abort_counter_cleared", iterator, 0);
      abort = 1'b1; #1;
      chk("abort_in_idle", counter_reset, 0);
      abort = 1'b0;
      base_value = 6'd10; length = 7'd2; start = 1'b1;
      tick(); start = 1'b0;
      tick(); #2;
      chk("restart_idx", elem_index, 10);
      chk("restart_valid", elem_valid, 1);
      tick(); tick(); #2;
      chk("restart_done", done, 1);
      tick();

      // Asynchronous reset mid-RUN
      base_value = 6'd3; length = 7'd5; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick(); #2;
      chk("mid_pre_valid", elem_valid, 1);
      reset = 1'b0; #1;
      chk("mid_busy", busy, 0);
      chk("mid_valid", elem_valid, 0);
      chk("mid_index", elem_index, 0);
      chk("mid_lv", counter_load_value, 0);
      chk("mid_ce", counter_clock_enable, 0);
      chk("mid_done", done, 0);
      start = 1'b1;
      tick(); #2;
      chk("mid_start_ignored", busy, 0);
      start = 1'b0;
      reset = 1'b1;
      tick(); #2;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_stall", stall_cycles, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
